// File: rtl/gon_tag_tx.sv
// GON multicast transmitter: buffers tagged words from the upstream loader in a
// small FIFO and drives them onto the GON bus for a programmed burst length.
module gon_tag_tx #(
   parameter int DATA_WIDTH = 64,
   parameter int TAG_WIDTH  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  burst_len,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] bus_data,
   output logic [TAG_WIDTH-1:0]  bus_tag,
   output logic                  bus_enable,
   input  logic                  bus_ready,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  sent_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]     OCC_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]     OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   // Pointers wrap by natural overflow, which only matches modulo FIFO_DEPTH
   // when the depth is a power of two.
   if ((1 << PTR_W) != FIFO_DEPTH || FIFO_DEPTH < 2) begin : g_bad_depth
      $error("gon_tag_tx: FIFO_DEPTH must be a power of two and >= 2");
   end

   logic [1:0]            state;
   logic [CNT_WIDTH-1:0]  len_q;
   logic [CNT_WIDTH-1:0]  accept_cnt;
   logic [CNT_WIDTH-1:0]  sent_next;

   logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
   logic [TAG_WIDTH-1:0]  tag_mem  [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W:0]        occ;

   logic in_send;
   logic full;
   logic empty;
   logic push;
   logic pop;

   assign in_send = (state == ST_SEND);
   assign full    = (occ == OCC_FULL);
   assign empty   = (occ == '0);

   // Both handshake outputs are pure functions of registers, so neither side
   // of the bus can form a combinational loop through this block.
   assign in_ready   = in_send && !full && (accept_cnt < len_q);
   assign bus_enable = in_send && !empty;
   assign bus_data   = bus_enable ? data_mem[rd_ptr] : '0;
   assign bus_tag    = bus_enable ? tag_mem[rd_ptr]  : '0;

   assign push      = in_valid && in_ready;
   assign pop       = bus_enable && bus_ready;
   assign sent_next = sent_count + CNT_ONE;

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   // NOTE: FIFO storage has no reset; stale entries are never visible because
   // the bus outputs are gated by the occupancy count, which is reset.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= in_data;
         tag_mem[wr_ptr]  <= in_tag;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         len_q      <= '0;
         accept_cnt <= '0;
         sent_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  len_q      <= burst_len;
                  accept_cnt <= '0;
                  sent_count <= '0;
                  state      <= (burst_len == '0) ? ST_DONE : ST_SEND;
               end
            end
            ST_SEND: begin
               if (push) accept_cnt <= accept_cnt + CNT_ONE;
               if (pop) begin
                  sent_count <= sent_next;
                  if (sent_next == len_q) state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A word offered to the bus stays put until the receivers take it.
   a_head_stable : assert property (@(posedge clk) disable iff (!reset)
      (bus_enable && !bus_ready) |=> (bus_enable && $stable(bus_data) && $stable(bus_tag)));

   a_occ_bound : assert property (@(posedge clk) disable iff (!reset)
      occ <= OCC_FULL);

endmodule

// File: tb/tb_gon_tag_tx.sv
// Scoreboard bench for gon_tag_tx: accepted upstream words are queued and
// compared in order against every word retired on the GON bus.
module tb_gon_tag_tx;

   localparam int DW    = 64;
   localparam int TW    = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [CW-1:0] burst_len;
   logic [DW-1:0] in_data;
   logic [TW-1:0] in_tag;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] bus_data;
   logic [TW-1:0] bus_tag;
   logic          bus_enable;
   logic          bus_ready;
   logic          busy;
   logic          done;
   logic [CW-1:0] sent_count;

   gon_tag_tx #(
      .DATA_WIDTH (DW),
      .TAG_WIDTH  (TW),
      .FIFO_DEPTH (DEPTH),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .burst_len  (burst_len),
      .in_data    (in_data),
      .in_tag     (in_tag),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .bus_data   (bus_data),
      .bus_tag    (bus_tag),
      .bus_enable (bus_enable),
      .bus_ready  (bus_ready),
      .busy       (busy),
      .done       (done),
      .sent_count (sent_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Stimulus/monitor shared state
   logic [TW+DW-1:0] sb[$];
   logic [TW+DW-1:0] exp_w;
   int   acc = 0, cur_len = 0, tag_base = 0, burst_id = 0;
   int   vmode = 0, rmode = 0;
   int   n_push = 0, n_pop = 0, n_done = 0, cyc = 0;
   int   push_base = 0, pop_base = 0, done_base = 0;
   int   last_pop_cyc = 0, done_cyc = 0;
   logic gap_chk = 1'b0, prev_push = 1'b0, hold_valid = 1'b0;
   logic push_now, pop_now;
   logic [DW-1:0] hold_data;
   logic [TW-1:0] hold_tag;

   function automatic logic [DW-1:0] word(input int i);
      return {16'hC0DE, 16'(burst_id), 32'(i) * 32'h9E37_79B9 + 32'h1357};
   endfunction

   // Monitor on the falling edge, where inputs and outputs are settled.
   always @(negedge clk) begin
      if (!reset) begin
         hold_valid = 1'b0;
         prev_push  = 1'b0;
      end else begin
         cyc++;
         push_now = in_valid && in_ready;
         pop_now  = bus_enable && bus_ready;
         if (!bus_enable) begin
            check("idle_bus_data", bus_data, 64'd0);
            check("idle_bus_tag", 64'(bus_tag), 64'd0);
         end
         if (hold_valid) begin
            check("hold_en", 64'(bus_enable), 64'd1);
            check("hold_data", bus_data, hold_data);
            check("hold_tag", 64'(bus_tag), 64'(hold_tag));
         end
         hold_valid = bus_enable && !bus_ready;
         hold_data  = bus_data;
         hold_tag   = bus_tag;
         if (gap_chk && busy) check("gap_en", 64'(bus_enable), 64'(prev_push));
         prev_push = push_now;
         if (busy && !done && acc >= cur_len) check("in_ready_cap", 64'(in_ready), 64'd0);
         if (pop_now) begin
            n_pop++;
            last_pop_cyc = cyc;
            if (sb.size() == 0) begin
               check("pop_unexpected", 64'd1, 64'd0);
            end else begin
               exp_w = sb.pop_front();
               check("bus_data", bus_data, exp_w[DW-1:0]);
               check("bus_tag", 64'(bus_tag), 64'(exp_w[DW+:TW]));
            end
         end
         if (push_now) begin
            sb.push_back({in_tag, in_data});
            acc++;
            n_push++;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      in_data = word(acc);
      in_tag  = TW'(tag_base + acc);
      case (vmode)
         0:       in_valid = 1'b0;
         1:       in_valid = 1'b1;
         default: in_valid = !in_valid;
      endcase
      case (rmode)
         0:       bus_ready = 1'b0;
         1:       bus_ready = 1'b1;
         default: bus_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_bus_en"}, 64'(bus_enable), 64'd0);
      check({tag, "_bus_data"}, bus_data, 64'd0);
      check({tag, "_bus_tag"}, 64'(bus_tag), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_sent"}, 64'(sent_count), 64'd0);
   endtask

   task automatic start_burst(input int len, input int tb, input int vm, input int rm);
      burst_id++;
      acc       = 0;
      tag_base  = tb;
      cur_len   = len;
      vmode     = vm;
      rmode     = rm;
      done_base = n_done;
      pop_base  = n_pop;
      push_base = n_push;
      start     = 1'b1;
      burst_len = CW'(len);
      cycle();
      start = 1'b0;
   endtask

   task automatic finish_burst(input string tag, input int budget);
      for (int i = 0; i < budget && n_done == done_base; i++) cycle();
      check({tag, "_done_seen"}, 64'(n_done - done_base), 64'd1);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
      check({tag, "_sent"}, 64'(sent_count), 64'(cur_len));
      check({tag, "_pops"}, 64'(n_pop - pop_base), 64'(cur_len));
      check({tag, "_pushes"}, 64'(n_push - push_base), 64'(cur_len));
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
      if (cur_len > 0) check({tag, "_done_lat"}, 64'(done_cyc), 64'(last_pop_cyc + 1));
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; burst_len = '0;
      in_data = '0; in_tag = '0; in_valid = 1'b0; bus_ready = 1'b0;
      void'($urandom(32'd2024));

      repeat (3) @(posedge clk);
      #1;
      check_idle("por");
      reset = 1'b1;
      cycle();
      check_idle("post_rel");

      // Basic burst, tags 1/2/3, full-rate both sides
      start_burst(3, 1, 1, 1);
      finish_burst("basic", 40);

      // Backpressure: receivers stalled, FIFO fills to depth
      start_burst(6, 5, 1, 0);
      repeat (10) cycle();
      check("bp_pushes", 64'(n_push - push_base), 64'(DEPTH));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_bus_en", 64'(bus_enable), 64'd1);
      rmode = 1;
      finish_burst("bp", 60);

      // Upstream gaps: bus_enable follows each arrival one cycle later
      start_burst(4, 8, 2, 1);
      gap_chk = 1'b1;
      finish_burst("gap", 40);
      gap_chk = 1'b0;

      // Zero-length burst: done next cycle, nothing on the bus
      vmode = 1; rmode = 1; cur_len = 0;
      pop_base = n_pop; push_base = n_push;
      start = 1'b1; burst_len = '0;
      cycle();
      start = 1'b0;
      check("zero_done", 64'(done), 64'd1);
      check("zero_bus_en", 64'(bus_enable), 64'd0);
      check("zero_sent", 64'(sent_count), 64'd0);
      cycle();
      check("zero_done_end", 64'(done), 64'd0);
      check("zero_busy_end", 64'(busy), 64'd0);
      check("zero_pops", 64'(n_pop - pop_base), 64'd0);
      check("zero_pushes", 64'(n_push - push_base), 64'd0);

      // start during SEND must not disturb the running burst
      start_burst(5, 0, 1, 0);
      repeat (3) cycle();
      start = 1'b1; burst_len = CW'(2);
      cycle();
      start = 1'b0;
      check("ign_busy", 64'(busy), 64'd1);
      rmode = 1;
      finish_burst("ign", 60);

      // Pointer wrap with random receiver stalls
      start_burst(9, 12, 1, 2);
      finish_burst("wrap", 300);

      // Reset mid-burst: everything flushed, no done pulse
      start_burst(6, 3, 1, 0);
      repeat (3) cycle();
      reset = 1'b0;
      #1;
      check_idle("rst_assert");
      repeat (3) cycle();
      check_idle("rst_hold");
      reset = 1'b1;
      sb.delete();
      cycle();
      check_idle("rst_release");
      check("rst_no_done", 64'(n_done - done_base), 64'd0);

      start_burst(3, 1, 1, 1);
      finish_burst("after_rst", 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
